motor_ramp_ctrl: RTL and testbench

- Soft-start/soft-stop sequencer for the elevator car motor.
- Drives the configuration inputs of the shared timer/PWM engine: mode, prescaler, period and compare.
- Ramps duty in fixed steps, one step per completed PWM period, between 0 and a latched target.
- Sits between the floor/motion control FSM (start/stop/estop) and the PWM timer instance.

---
 rtl/motor_pkg.sv | 17 +
 rtl/ramp_step_sat.sv | 32 +++
 rtl/motor_ramp_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor soft-start/soft-stop sequencer:
// FSM state encoding, timer mode codes and the default data width.
package motor_pkg;

  localparam int unsigned DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [1:0] TMR_OFF = 2'b00;
  localparam logic [1:0] TMR_PWM = 2'b10;

endpackage

// File: rtl/ramp_step_sat.sv
// Combinational saturating duty step.
//   up       : 1 = add step (clamped to target), 0 = subtract step (floored at 0)
//   compare  : current duty compare
//   step     : latched step size (never 0)
//   target   : latched ramp target
//   result_c : next duty compare
// Arithmetic is done at DW+1 bits so the add can never wrap.
module ramp_step_sat
  import motor_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          up,
  input  logic [DW-1:0] compare,
  input  logic [DW-1:0] step,
  input  logic [DW-1:0] target,
  output logic [DW-1:0] result_c
);

  logic [DW:0] sum_c;

  always_comb begin
    sum_c    = {1'b0, compare} + {1'b0, step};
    result_c = '0;
    if (up) begin
      result_c = (sum_c >= {1'b0, target}) ? target : sum_c[DW-1:0];
    end else begin
      result_c = (compare > step) ? (compare - step) : '0;
    end
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Elevator motor soft-start/soft-stop sequencer. Drives the configuration of
// the shared PWM timer and ramps duty one step per completed PWM period.
// Optional build macro RAMP_TIMEOUT_EN adds a ramp watchdog and sticky fault.
// Ports:
//   clk, reset_n               : clock, async active-low reset
//   start, stop                : single-cycle command pulses
//   estop                      : level, immediate motor off
//   target_duty, step,
//   period_ticks, prescale     : ramp settings, sampled on an accepted start
//   period_done                : one pulse per PWM period wrap
//   tmr_mode, tmr_prescale,
//   tmr_max_count, tmr_compare : timer configuration outputs
//   busy, at_speed, done_irq   : status
//   fault                      : sticky ramp timeout (0 unless RAMP_TIMEOUT_EN)
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int unsigned DW          = DW_DEFAULT,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          estop,
  input  logic [DW-1:0] target_duty,
  input  logic [DW-1:0] step,
  input  logic [DW-1:0] period_ticks,
  input  logic [DW-1:0] prescale,
  input  logic          period_done,
  output logic [1:0]    tmr_mode,
  output logic [DW-1:0] tmr_prescale,
  output logic [DW-1:0] tmr_max_count,
  output logic [DW-1:0] tmr_compare,
  output logic          busy,
  output logic          at_speed,
  output logic          done_irq,
  output logic          fault
);

  state_t        state, state_n;
  logic [DW-1:0] compare_n, target_l, target_n, step_l, step_n;
  logic [DW-1:0] prescale_n, period_n;
  logic [1:0]    mode_n;
  logic          busy_n, at_speed_n, done_n, accept_c;
  logic [DW:0]   full_duty_c;
  logic [DW-1:0] target_c, step_res_c;

  // Target is clamped to period_ticks+1 (100% duty); zero step means 1.
  always_comb begin
    full_duty_c = {1'b0, period_ticks} + (DW+1)'(1);
    target_c    = ({1'b0, target_duty} < full_duty_c) ? target_duty : full_duty_c[DW-1:0];
  end

  ramp_step_sat #(.DW(DW)) u_step (
    .up       (state == RAMP_UP),
    .compare  (tmr_compare),
    .step     (step_l),
    .target   (target_l),
    .result_c (step_res_c)
  );

`ifdef RAMP_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_n;
  logic        fault_q, fault_n;
  assign fault = fault_q;
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT_CYC;
  assign fault = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      tmr_compare   <= '0;
      target_l      <= '0;
      step_l        <= '0;
      tmr_prescale  <= '0;
      tmr_max_count <= '0;
      tmr_mode      <= TMR_OFF;
      busy          <= 1'b0;
      at_speed      <= 1'b0;
      done_irq      <= 1'b0;
`ifdef RAMP_TIMEOUT_EN
      cnt_q         <= '0;
      fault_q       <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      tmr_compare   <= compare_n;
      target_l      <= target_n;
      step_l        <= step_n;
      tmr_prescale  <= prescale_n;
      tmr_max_count <= period_n;
      tmr_mode      <= mode_n;
      busy          <= busy_n;
      at_speed      <= at_speed_n;
      done_irq      <= done_n;
`ifdef RAMP_TIMEOUT_EN
      cnt_q         <= cnt_n;
      fault_q       <= fault_n;
`endif
    end
  end

  // Next-state and output logic; estop overrides everything, stop beats start.
  always_comb begin
    state_n    = state;
    compare_n  = tmr_compare;
    target_n   = target_l;
    step_n     = step_l;
    prescale_n = tmr_prescale;
    period_n   = tmr_max_count;
    mode_n     = tmr_mode;
    done_n     = 1'b0;
    accept_c   = start & ~stop & ~estop;
`ifdef RAMP_TIMEOUT_EN
    cnt_n      = '0;
    fault_n    = fault_q;
`endif

    if (estop) begin
      state_n   = IDLE;
      compare_n = '0;
      mode_n    = TMR_OFF;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            target_n   = target_c;
            step_n     = (step == '0) ? DW'(1) : step;
            prescale_n = prescale;
            period_n   = period_ticks;
            mode_n     = TMR_PWM;
            state_n    = (target_c == '0) ? RUN : RAMP_UP;
`ifdef RAMP_TIMEOUT_EN
            fault_n    = 1'b0;
`endif
          end
        end
        RAMP_UP: begin
          if (stop) begin
            state_n = RAMP_DOWN;
          end else if (period_done) begin
            compare_n = step_res_c;
            if (step_res_c == target_l) state_n = RUN;
          end
        end
        RUN: begin
          if (stop) state_n = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          // Resume ramp-up from the current compare; timer mode untouched.
          if (accept_c) begin
            target_n   = target_c;
            step_n     = (step == '0) ? DW'(1) : step;
            prescale_n = prescale;
            period_n   = period_ticks;
            state_n    = RAMP_UP;
`ifdef RAMP_TIMEOUT_EN
            fault_n    = 1'b0;
`endif
          end else if (period_done) begin
            compare_n = step_res_c;
            if (step_res_c == '0) begin
              state_n = IDLE;
              mode_n  = TMR_OFF;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

`ifdef RAMP_TIMEOUT_EN
    // Watchdog: counts idle ramp cycles, cleared by period_done or state change.
    if (!estop && (state == RAMP_UP || state == RAMP_DOWN) &&
        state_n == state && !period_done) begin
      if (cnt_q == TIMEOUT_CYC - 32'd1) begin
        fault_n   = 1'b1;
        state_n   = IDLE;
        compare_n = '0;
        mode_n    = TMR_OFF;
      end else begin
        cnt_n = cnt_q + 32'd1;
      end
    end
`endif

    busy_n     = (state_n != IDLE);
    at_speed_n = (state_n == RUN);
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl: table of single-cycle vectors plus
// hand-written sequences for clamping, async reset and the optional watchdog.
module tb_motor_ramp_ctrl;
  import motor_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NV = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, estop = 1'b0, period_done = 1'b0;
  logic [DW-1:0] target_duty = '0, step_in = '0, period_ticks = '0, prescale = '0;
  logic [1:0]    tmr_mode;
  logic [DW-1:0] tmr_prescale, tmr_max_count, tmr_compare;
  logic          busy, at_speed, done_irq, fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  motor_ramp_ctrl #(.DW(DW), .TIMEOUT_CYC(32'd16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stop          (stop),
    .estop         (estop),
    .target_duty   (target_duty),
    .step          (step_in),
    .period_ticks  (period_ticks),
    .prescale      (prescale),
    .period_done   (period_done),
    .tmr_mode      (tmr_mode),
    .tmr_prescale  (tmr_prescale),
    .tmr_max_count (tmr_max_count),
    .tmr_compare   (tmr_compare),
    .busy          (busy),
    .at_speed      (at_speed),
    .done_irq      (done_irq),
    .fault         (fault)
  );

  typedef struct {
    logic          st, sp, es, pd;
    logic [DW-1:0] e_cmp;
    logic [1:0]    e_mode;
    logic          e_busy, e_at, e_done;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, sp, es, pd, input logic [DW-1:0] cmp,
                              input logic [1:0] mode, input logic b, a, d);
    vec_t v;
    v.st = st; v.sp = sp; v.es = es; v.pd = pd;
    v.e_cmp = cmp; v.e_mode = mode; v.e_busy = b; v.e_at = a; v.e_done = d;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // One clock: drive on negedge, sample 1 time unit after the posedge.
  task automatic cycle(input logic st, sp, es, pd);
    @(negedge clk);
    start = st; stop = sp; estop = es; period_done = pd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".compare"}, 0, tmr_compare, '0);
    chk({nm, ".mode"}, 0, DW'(tmr_mode), '0);
    chk({nm, ".busy"}, 0, DW'(busy), '0);
    chk({nm, ".at_speed"}, 0, DW'(at_speed), '0);
    chk({nm, ".done"}, 0, DW'(done_irq), '0);
    chk({nm, ".max_count"}, 0, tmr_max_count, '0);
    chk({nm, ".prescale"}, 0, tmr_prescale, '0);
    chk({nm, ".fault"}, 0, DW'(fault), '0);
  endtask

  initial begin
    //               st sp es pd  cmp  mode     busy at done
    vecs[0]  = mk(1, 0, 0, 0,  0, TMR_PWM, 1, 0, 0); // start -> RAMP_UP
    vecs[1]  = mk(0, 0, 0, 0,  0, TMR_PWM, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 20, TMR_PWM, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 40, TMR_PWM, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 50, TMR_PWM, 1, 1, 0); // clamp to target, RUN
    vecs[5]  = mk(0, 0, 0, 0, 50, TMR_PWM, 1, 1, 0);
    vecs[6]  = mk(1, 0, 0, 1, 50, TMR_PWM, 1, 1, 0); // start/pd ignored in RUN
    vecs[7]  = mk(0, 1, 0, 0, 50, TMR_PWM, 1, 0, 0); // stop -> RAMP_DOWN
    vecs[8]  = mk(0, 0, 0, 1, 30, TMR_PWM, 1, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 10, TMR_PWM, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 1,  0, TMR_OFF, 0, 0, 1); // done_irq
    vecs[11] = mk(0, 0, 0, 0,  0, TMR_OFF, 0, 0, 0); // done_irq one cycle only
    vecs[12] = mk(1, 1, 0, 0,  0, TMR_OFF, 0, 0, 0); // start+stop: stop wins
    vecs[13] = mk(0, 1, 0, 0,  0, TMR_OFF, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 1,  0, TMR_OFF, 0, 0, 0);
    vecs[15] = mk(1, 0, 0, 0,  0, TMR_PWM, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 1, 20, TMR_PWM, 1, 0, 0);
    vecs[17] = mk(0, 0, 0, 1, 40, TMR_PWM, 1, 0, 0);
    vecs[18] = mk(0, 1, 0, 1, 40, TMR_PWM, 1, 0, 0); // stop+pd: no step
    vecs[19] = mk(1, 0, 0, 0, 40, TMR_PWM, 1, 0, 0); // resume ramp-up
    vecs[20] = mk(0, 0, 1, 0,  0, TMR_OFF, 0, 0, 0); // estop in RAMP_UP
    vecs[21] = mk(1, 0, 1, 0,  0, TMR_OFF, 0, 0, 0); // start blocked by estop
    vecs[22] = mk(1, 0, 0, 0,  0, TMR_PWM, 1, 0, 0);
    vecs[23] = mk(0, 0, 0, 1, 20, TMR_PWM, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    target_duty = 32'd50; step_in = 32'd20; period_ticks = 32'd99; prescale = 32'd7;
    for (int i = 0; i < int'(NV); i++) begin
      cycle(vecs[i].st, vecs[i].sp, vecs[i].es, vecs[i].pd);
      chk("compare", i, tmr_compare, vecs[i].e_cmp);
      chk("mode", i, DW'(tmr_mode), DW'(vecs[i].e_mode));
      chk("busy", i, DW'(busy), DW'(vecs[i].e_busy));
      chk("at_speed", i, DW'(at_speed), DW'(vecs[i].e_at));
      chk("done_irq", i, DW'(done_irq), DW'(vecs[i].e_done));
      chk("max_count", i, tmr_max_count, 32'd99);
      chk("prescale", i, tmr_prescale, 32'd7);
      chk("fault", i, DW'(fault), '0);
    end

    // Clamp: target 500 limited to period+1 = 100, zero step acts as 1.
    cycle(0, 0, 1, 0);
    target_duty = 32'd500; step_in = 32'd0; prescale = 32'd3;
    cycle(1, 0, 0, 0);
    chk("clamp.mode", 0, DW'(tmr_mode), DW'(TMR_PWM));
    chk("clamp.prescale", 0, tmr_prescale, 32'd3);
    for (int i = 1; i <= 100; i++) begin
      cycle(0, 0, 0, 1);
      chk("clamp.compare", i, tmr_compare, DW'(i));
      chk("clamp.at_speed", i, DW'(at_speed), (i == 100) ? DW'(1) : DW'(0));
    end
    cycle(0, 0, 0, 1);
    chk("run_hold.compare", 0, tmr_compare, 32'd100);

    // Ramp-down by 1, then async reset mid-cycle.
    cycle(0, 1, 0, 0);
    chk("down.at_speed", 0, DW'(at_speed), '0);
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 0, 1);
      chk("down.compare", i, tmr_compare, DW'(100 - i));
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    period_done = 1'b0;
    reset_n = 1'b1;

`ifdef RAMP_TIMEOUT_EN
    // Watchdog: 16 cycles in RAMP_UP without period_done.
    target_duty = 32'd50; step_in = 32'd20; period_ticks = 32'd99;
    cycle(1, 0, 0, 0);
    repeat (15) cycle(0, 0, 0, 0);
    chk("timeout.early_fault", 0, DW'(fault), '0);
    chk("timeout.early_busy", 0, DW'(busy), 32'd1);
    cycle(0, 0, 0, 0);
    chk("timeout.fault", 0, DW'(fault), 32'd1);
    chk("timeout.mode", 0, DW'(tmr_mode), DW'(TMR_OFF));
    chk("timeout.busy", 0, DW'(busy), '0);
    chk("timeout.compare", 0, tmr_compare, '0);
    chk("timeout.done", 0, DW'(done_irq), '0);
    cycle(1, 0, 0, 0);
    chk("timeout.clear", 0, DW'(fault), '0);
    chk("timeout.restart", 0, DW'(tmr_mode), DW'(TMR_PWM));
    cycle(0, 0, 1, 0);
`endif

    cycle(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
